// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, FSM state encoding and the flag bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_ABS = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic carry;
    logic sign;
    logic over;
    logic zero;
  } flags_t;

endpackage

// File: rtl/alu_core.sv
// 8-bit ALU datapath: add, sub, and, or, xor, not, shl, abs with carry/sign/over/zero flags.
// Latency: purely combinational.
// Backpressure: none; the caller registers the outputs.
// Ports: i_op opcode, i_a/i_b operands, o_result, o_carry/o_sign/o_over/o_zero flags.
module alu_core
  import alu_pkg::*;
(
  input  logic [2:0] i_op,
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic [7:0] o_result,
  output logic       o_carry,
  output logic       o_sign,
  output logic       o_over,
  output logic       o_zero
);

  logic [8:0] w_sum;
  logic [7:0] w_res;
  logic       w_carry;
  logic       w_over;

  always_comb begin
    w_sum   = '0;
    w_res   = '0;
    w_carry = 1'b0;
    w_over  = 1'b0;
    case (i_op)
      OP_ADD: begin
        w_sum   = {1'b0, i_a} + {1'b0, i_b};
        w_res   = w_sum[7:0];
        w_carry = w_sum[8];
        w_over  = (i_a[7] == i_b[7]) && (w_res[7] != i_a[7]);
      end
      OP_SUB: begin
        // Subtract as A + ~B + 1 so carry-out reads as "no borrow".
        w_sum   = {1'b0, i_a} + {1'b0, ~i_b} + 9'd1;
        w_res   = w_sum[7:0];
        w_carry = w_sum[8];
        w_over  = (i_a[7] != i_b[7]) && (w_res[7] != i_a[7]);
      end
      OP_AND:  w_res = i_a & i_b;
      OP_OR:   w_res = i_a | i_b;
      OP_XOR:  w_res = i_a ^ i_b;
      OP_NOT:  w_res = ~i_a;
      OP_SHL:  w_res = {i_a[6:0], 1'b0};
      // abs(0x80) wraps back to 0x80, the natural two's complement result.
      OP_ABS:  w_res = i_a[7] ? (~i_a + 8'd1) : i_a;
      default: w_res = '0;
    endcase
  end

  assign o_result = w_res;
  assign o_carry  = w_carry;
  assign o_over   = w_over;
  assign o_sign   = w_res[7];
  assign o_zero   = (w_res == 8'd0);

endmodule

// File: rtl/alu_arbiter.sv
// Shares one alu_core among N_REQ requesters; round-robin grant, one operation in flight.
// Latency: accept at edge t, registered response valid from edge t+1; >= 3 cycles per operation.
// Backpressure: response held stable until rsp_ready; no request accepted outside IDLE.
// Ports: clk/rst (sync, active-high); req_valid/req_ready/req_op/req_a/req_b packed per requester;
//        rsp_valid/rsp_ready handshake with rsp_id, rsp_data and rsp_carry/sign/over/zero flags.
// Build option: define ALU_FIXED_PRIO_EN for fixed priority (lowest index wins, pointer held at 0).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [3*N_REQ-1:0]   req_op,
  input  logic [8*N_REQ-1:0]   req_a,
  input  logic [8*N_REQ-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_data,
  output logic                 rsp_carry,
  output logic                 rsp_sign,
  output logic                 rsp_over,
  output logic                 rsp_zero
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ID_W-1:0] r_ptr;
  logic [2:0]      r_op;
  logic [7:0]      r_a;
  logic [7:0]      r_b;
  logic [ID_W-1:0] r_id;
  logic [7:0]      r_data;
  flags_t          r_flags;
  logic            r_rsp_valid;

  logic [2:0]      w_op_arr [N_REQ];
  logic [7:0]      w_a_arr  [N_REQ];
  logic [7:0]      w_b_arr  [N_REQ];

  logic [ID_W-1:0] w_gnt;
  logic            w_gnt_vld;
  logic [ID_W:0]   w_cand_sum;
  logic [ID_W-1:0] w_cand;
  logic            w_accept;

  logic [7:0]      w_res;
  flags_t          w_flags;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_op_arr[gi] = req_op[3*gi +: 3];
    assign w_a_arr[gi]  = req_a[8*gi +: 8];
    assign w_b_arr[gi]  = req_b[8*gi +: 8];
  end

  // Scan from the pointer, wrapping modulo N_REQ; first valid wins.
  // In fixed-priority builds the pointer stays at 0, so this is lowest-index-first.
  always_comb begin
    w_gnt      = '0;
    w_gnt_vld  = 1'b0;
    w_cand_sum = '0;
    w_cand     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_cand_sum >= (ID_W+1)'(N_REQ)) begin
        w_cand_sum = w_cand_sum - (ID_W+1)'(N_REQ);
      end
      w_cand = w_cand_sum[ID_W-1:0];
      if (!w_gnt_vld && req_valid[w_cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = w_cand;
      end
    end
  end

  assign w_accept = (r_state == IDLE) && w_gnt_vld;

`ifndef ALU_FIXED_PRIO_EN
  logic [ID_W:0]   w_ptr_sum;
  logic [ID_W-1:0] w_ptr_nxt;

  always_comb begin
    w_ptr_sum = {1'b0, w_gnt} + (ID_W+1)'(1);
    w_ptr_nxt = w_ptr_sum[ID_W-1:0];
    if (w_ptr_sum == (ID_W+1)'(N_REQ)) begin
      w_ptr_nxt = '0;
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and the combinational grant strobe.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    case (r_state)
      IDLE: begin
        if (w_gnt_vld) begin
          req_ready[w_gnt] = 1'b1;
          w_state_nxt      = EXEC;
        end
      end
      EXEC: w_state_nxt = RESP;
      RESP: begin
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  alu_core u_alu_core (
    .i_op     (r_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .o_result (w_res),
    .o_carry  (w_flags.carry),
    .o_sign   (w_flags.sign),
    .o_over   (w_flags.over),
    .o_zero   (w_flags.zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= '0;
      r_data      <= '0;
      r_flags     <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op <= w_op_arr[w_gnt];
        r_a  <= w_a_arr[w_gnt];
        r_b  <= w_b_arr[w_gnt];
        r_id <= w_gnt;
`ifdef ALU_FIXED_PRIO_EN
        r_ptr <= '0;
`else
        r_ptr <= w_ptr_nxt;
`endif
      end
      if (r_state == EXEC) begin
        r_data      <= w_res;
        r_flags     <= w_flags;
        r_rsp_valid <= 1'b1;
      end else if ((r_state == RESP) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_id;
  assign rsp_data  = r_data;
  assign rsp_carry = r_flags.carry;
  assign rsp_sign  = r_flags.sign;
  assign rsp_over  = r_flags.over;
  assign rsp_zero  = r_flags.zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, backpressure, reset abort, arbitration order.
// Latency: n/a.
// Backpressure: exercised by holding rsp_ready low.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [3*N-1:0]   req_op = '0;
  logic [8*N-1:0]   req_a = '0;
  logic [8*N-1:0]   req_b = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [IW-1:0]    rsp_id;
  logic [7:0]       rsp_data;
  logic             rsp_carry, rsp_sign, rsp_over, rsp_zero;

  always #5 clk = ~clk;

  alu_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_carry (rsp_carry),
    .rsp_sign  (rsp_sign),
    .rsp_over  (rsp_over),
    .rsp_zero  (rsp_zero)
  );

  // fl packs {carry, sign, over, zero}.
  typedef struct {
    int         id;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [3:0] fl;
  } vec_t;

  typedef struct {
    int         id;
    logic [7:0] r;
    logic [3:0] fl;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t tv[13];
  int   errors = 0;
  int   checks = 0;
  int   g_idx;
  int   n_gnt;
  int   exp_id;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every accepted response must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got id %0d data 0x%0h, required no response", rsp_id, rsp_data);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_id",    32'(rsp_id), 32'(mon_e.id));
        chk("rsp_data",  32'(rsp_data), 32'(mon_e.r));
        chk("rsp_flags", 32'({rsp_carry, rsp_sign, rsp_over, rsp_zero}), 32'(mon_e.fl));
      end
    end
  end

  // Present one request, wait for its grant, drop valid after the accept edge.
  task automatic issue(input int id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input bit push, input logic [7:0] r, input logic [3:0] fl);
    bit   got;
    exp_t e;
    got = 1'b0;
    req_op[3*id +: 3] = op;
    req_a[8*id +: 8]  = a;
    req_b[8*id +: 8]  = b;
    req_valid[id]     = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        got = 1'b1;
        break;
      end
    end
    chk("grant_wait", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
    if (push && got) begin
      e.id = id;
      e.r  = r;
      e.fl = fl;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (sb.size() == 0 && !rsp_valid) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain", 32'(done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach its summary");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    tv[0]  = '{0, OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b0110};
    tv[1]  = '{1, OP_SUB, 8'h05, 8'h07, 8'hFE, 4'b0100};
    tv[2]  = '{2, OP_SUB, 8'h07, 8'h05, 8'h02, 4'b1000};
    tv[3]  = '{3, OP_ABS, 8'h80, 8'h00, 8'h80, 4'b0100};
    tv[4]  = '{0, OP_SHL, 8'h81, 8'h00, 8'h02, 4'b0000};
    tv[5]  = '{1, OP_XOR, 8'h5A, 8'h5A, 8'h00, 4'b0001};
    tv[6]  = '{2, OP_NOT, 8'h0F, 8'h00, 8'hF0, 4'b0100};
    tv[7]  = '{3, OP_OR,  8'h30, 8'h05, 8'h35, 4'b0000};
    tv[8]  = '{0, OP_ABS, 8'hFB, 8'h00, 8'h05, 4'b0000};
    tv[9]  = '{1, OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b1001};
    tv[10] = '{2, OP_SUB, 8'h80, 8'h01, 8'h7F, 4'b1010};
    tv[11] = '{3, OP_AND, 8'hC3, 8'h0F, 8'h03, 4'b0000};
    tv[12] = '{0, OP_ADD, 8'h80, 8'h80, 8'h00, 4'b1011};

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_id",    32'(rsp_id), 32'd0);
    chk("rst_rsp_data",  32'(rsp_data), 32'd0);
    chk("rst_flags",     32'({rsp_carry, rsp_sign, rsp_over, rsp_zero}), 32'd0);
    @(posedge clk);
    #1;

    // Vector table: one operation at a time, with latency check.
    for (int i = 0; i < 13; i++) begin
      issue(tv[i].id, tv[i].op, tv[i].a, tv[i].b, 1'b1, tv[i].r, tv[i].fl);
      @(negedge clk);
      chk("lat_exec_vld", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk("lat_resp_vld", 32'(rsp_valid), 32'd1);
      drain();
    end

    // Backpressure: hold the response for 5 cycles with another requester waiting.
    rsp_ready = 1'b0;
    issue(1, OP_ADD, 8'h10, 8'h20, 1'b1, 8'h30, 4'b0000);
    req_op[8:6]    = OP_OR;
    req_a[23:16]   = 8'h01;
    req_b[23:16]   = 8'h02;
    req_valid[2]   = 1'b1;
    @(negedge clk);
    chk("bp_exec_rdy", 32'(req_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_vld",  32'(rsp_valid), 32'd1);
      chk("bp_data", 32'(rsp_data), 32'h30);
      chk("bp_id",   32'(rsp_id), 32'd1);
      chk("bp_rdy",  32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_accept_rdy", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("bp_drop_vld", 32'(rsp_valid), 32'd0);
    chk("bp_regrant",  32'(req_ready), 32'b0100);
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    e.id = 2; e.r = 8'h03; e.fl = 4'b0000;
    sb.push_back(e);
    drain();

    // Reset while in EXEC: aborted, pointer returns to 0.
    issue(2, OP_ADD, 8'h01, 8'h01, 1'b0, 8'h00, 4'b0000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstx_vld",  32'(rsp_valid), 32'd0);
    chk("rstx_data", 32'(rsp_data), 32'd0);
    chk("rstx_rdy",  32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    req_op[5:3]   = OP_ADD; req_a[15:8]  = 8'h02; req_b[15:8]  = 8'h03;
    req_op[11:9]  = OP_SUB; req_a[31:24] = 8'h09; req_b[31:24] = 8'h09;
    req_valid     = 4'b1010;
    @(negedge clk);
    chk("rstx_ptr", 32'(req_ready), 32'b0010);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    e.id = 1; e.r = 8'h05; e.fl = 4'b0000;
    sb.push_back(e);
    issue(3, OP_SUB, 8'h09, 8'h09, 1'b1, 8'h00, 4'b1001);
    drain();

    // Reset while in RESP: pending response discarded.
    rsp_ready = 1'b0;
    issue(3, OP_XOR, 8'h0F, 8'hF0, 1'b0, 8'h00, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    chk("rstr_pre_vld", 32'(rsp_valid), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rstr_vld",  32'(rsp_valid), 32'd0);
    chk("rstr_data", 32'(rsp_data), 32'd0);
    chk("rstr_id",   32'(rsp_id), 32'd0);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;

    // Arbitration order with all requesters continuously valid.
    for (int i = 0; i < N; i++) begin
      req_op[3*i +: 3] = OP_AND;
      req_a[8*i +: 8]  = 8'(8'h11 * (i + 1));
      req_b[8*i +: 8]  = 8'hFF;
    end
    req_valid = '1;
    n_gnt = 0;
    for (int c = 0; c < 80 && n_gnt < 5; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        g_idx = 0;
        for (int i = 0; i < N; i++) begin
          if (req_ready[i]) g_idx = i;
        end
`ifdef ALU_FIXED_PRIO_EN
        exp_id = 0;
`else
        exp_id = n_gnt % N;
`endif
        chk("rr_onehot", 32'($countones(req_ready)), 32'd1);
        chk("rr_grant",  32'(g_idx), 32'(exp_id));
        e.id = g_idx; e.r = 8'(8'h11 * (g_idx + 1)); e.fl = 4'b0000;
        sb.push_back(e);
        n_gnt++;
      end
    end
    chk("rr_count", 32'(n_gnt), 32'd5);
    @(posedge clk);
    #1;
    req_valid = '0;
    drain();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
